base3_digit_serializer: RTL and testbench



---
 rtl/base3_pkg.sv | 28 ++
 rtl/base3_digit_serializer.sv | 104 ++++++++++
 tb/tb_base3_digit_serializer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/base3_pkg.sv
// rtl/base3_pkg.sv - shared widths, trit codes and serializer state encoding for the base-3 path
package base3_pkg;

    localparam int NUM_TRITS = 16;
    localparam int TRIT_W    = 2;
    localparam int WORD_W    = NUM_TRITS * TRIT_W;
    localparam int IDX_W     = $clog2(NUM_TRITS);

    localparam logic [TRIT_W-1:0] TRIT_0   = 2'b00;
    localparam logic [TRIT_W-1:0] TRIT_1   = 2'b01;
    localparam logic [TRIT_W-1:0] TRIT_2   = 2'b10;
    localparam logic [TRIT_W-1:0] TRIT_BAD = 2'b11;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TRITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [TRIT_W-1:0] get_trit(input logic [WORD_W-1:0] word,
                                                   input logic [IDX_W-1:0]  i);
        return word[i*TRIT_W +: TRIT_W];
    endfunction

endpackage

// File: rtl/base3_digit_serializer.sv
// rtl/base3_digit_serializer.sv - emits a captured packed base-3 word one trit per beat, MSB first
// Optional leading-zero suppression is enabled by defining LEAD_ZERO_SUPPRESS_EN.
module base3_digit_serializer
    import base3_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] base3_no,
    input  logic              load,
    output logic              busy,
    output logic [TRIT_W-1:0] digit_out,
    output logic              digit_valid,
    input  logic              digit_ready,
    output logic              digit_last,
    output logic              frame_done,
    output logic              err
);

    state_t             state;
    logic [WORD_W-1:0]  shreg;
    logic [IDX_W-1:0]   idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            idx         <= '0;
            busy        <= 1'b0;
            digit_out   <= TRIT_0;
            digit_valid <= 1'b0;
            digit_last  <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg <= base3_no;
                        err   <= 1'b0;
                        busy  <= 1'b1;
`ifdef LEAD_ZERO_SUPPRESS_EN
                        // The top trit is examined here so a nonzero MSB costs no skip cycle.
                        if (get_trit(base3_no, IDX_LAST) == TRIT_0) begin
                            state <= SKIP;
                            idx   <= IDX_LAST - 1'b1;
                        end else begin
                            state       <= SEND;
                            idx         <= IDX_LAST;
                            digit_valid <= 1'b1;
                            digit_out   <= get_trit(base3_no, IDX_LAST);
                            digit_last  <= (IDX_LAST == '0);
                        end
`else
                        state       <= SEND;
                        idx         <= IDX_LAST;
                        digit_valid <= 1'b1;
                        digit_out   <= get_trit(base3_no, IDX_LAST);
                        digit_last  <= (IDX_LAST == '0);
`endif
                    end
                end
`ifdef LEAD_ZERO_SUPPRESS_EN
                SKIP: begin
                    if (get_trit(shreg, idx) == TRIT_0 && idx != '0) begin
                        idx <= idx - 1'b1;
                    end else begin
                        state       <= SEND;
                        digit_valid <= 1'b1;
                        digit_out   <= get_trit(shreg, idx);
                        digit_last  <= (idx == '0);
                    end
                end
`endif
                SEND: begin
                    if (digit_ready) begin
                        if (digit_out == TRIT_BAD) begin
                            err <= 1'b1;
                        end
                        if (idx == '0) begin
                            state       <= DONE;
                            digit_valid <= 1'b0;
                            digit_last  <= 1'b0;
                            digit_out   <= TRIT_0;
                            frame_done  <= 1'b1;
                        end else begin
                            idx        <= idx - 1'b1;
                            digit_out  <= get_trit(shreg, idx - 1'b1);
                            digit_last <= (idx == IDX_W'(1));
                        end
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_base3_digit_serializer.sv
// tb/tb_base3_digit_serializer.sv - scoreboard bench for base3_digit_serializer
module tb_base3_digit_serializer;
    import base3_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [WORD_W-1:0] base3_no;
    logic              load;
    logic              busy;
    logic [TRIT_W-1:0] digit_out;
    logic              digit_valid;
    logic              digit_ready;
    logic              digit_last;
    logic              frame_done;
    logic              err;

    always #5 clk = ~clk;

    base3_digit_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .base3_no    (base3_no),
        .load        (load),
        .busy        (busy),
        .digit_out   (digit_out),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .digit_last  (digit_last),
        .frame_done  (frame_done),
        .err         (err)
    );

`ifdef LEAD_ZERO_SUPPRESS_EN
    localparam int F6 = 15;
    localparam int F0 = 16;
    localparam int F3 = 16;
`else
    localparam int F6 = 1;
    localparam int F0 = 1;
    localparam int F3 = 1;
`endif

    typedef struct packed {
        logic [1:0] d;
        logic       l;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_expected(input logic [31:0] v);
        int   i;
        exp_t e;
        logic [1:0] t;
        i = 15;
`ifdef LEAD_ZERO_SUPPRESS_EN
        while (i > 0 && v[2*i +: 2] == 2'b00) i--;
`endif
        for (int j = i; j >= 0; j--) begin
            t   = v[2*j +: 2];
            e.d = t;
            e.l = (j == 0);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && digit_valid && digit_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_digit", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("digit", {30'd0, digit_out}, {30'd0, e.d});
                check("last", {31'd0, digit_last}, {31'd0, e.l});
            end
        end
    end

    task automatic run_frame(input logic [31:0] v, input int stall_at, input int abort_at,
                             input int exp_first, input int exp_fd, input logic exp_err,
                             input string tag);
        int         first_k = -1;
        int         fd_k = -1;
        int         fd_cnt = 0;
        int         acc = 0;
        int         stall_left = 0;
        int         ab = 0;
        bit         stalled = 0;
        bit         have_hold = 0;
        logic [1:0] hold_d = 2'b00;
        logic       hold_l = 1'b0;
        push_expected(v);
        @(posedge clk); #1;
        base3_no    = v;
        load        = 1'b1;
        digit_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ab == 2) begin
                check({tag, "_rst_busy"}, busy, 0);
                check({tag, "_rst_valid"}, digit_valid, 0);
                check({tag, "_rst_last"}, digit_last, 0);
                check({tag, "_rst_done"}, frame_done, 0);
                check({tag, "_rst_err"}, err, 0);
                check({tag, "_rst_digit"}, digit_out, 0);
                exp_q.delete();
                break;
            end
            if (digit_valid && first_k < 0) first_k = k;
            if (frame_done) begin
                fd_cnt++;
                if (fd_k < 0) fd_k = k;
            end
            if (k == 1) begin
                check({tag, "_busy_run"}, busy, 1);
                check({tag, "_err_clear"}, err, 0);
            end
            if (digit_valid && digit_last) check({tag, "_err_before_last"}, err, 0);
            if (!digit_ready) begin
                if (!have_hold) begin
                    hold_d    = digit_out;
                    hold_l    = digit_last;
                    have_hold = 1;
                end else begin
                    check({tag, "_stall_digit"}, digit_out, hold_d);
                    check({tag, "_stall_last"}, digit_last, hold_l);
                    check({tag, "_stall_valid"}, digit_valid, 1);
                end
            end
            if (digit_valid && digit_ready && !rst) acc++;
            if (fd_k >= 0 && k == fd_k + 1) begin
                check({tag, "_done_one_cycle"}, frame_done, 0);
                check({tag, "_idle_busy"}, busy, 0);
                break;
            end
            @(posedge clk); #1;
            load     = 1'b0;
            base3_no = v;
            if (k == 3) begin
                load     = 1'b1;
                base3_no = ~v;
            end
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) digit_ready = 1'b1;
            end else if (stall_at >= 0 && !stalled && acc == stall_at) begin
                digit_ready = 1'b0;
                stall_left  = 3;
                stalled     = 1;
            end
            if (ab == 1) begin
                rst = 1'b0;
                ab  = 2;
            end else if (abort_at >= 0 && ab == 0 && acc == abort_at) begin
                check({tag, "_pending_at_abort"}, exp_q.size(), 16 - abort_at);
                rst = 1'b1;
                ab  = 1;
            end
        end
        load = 1'b0;
        if (abort_at >= 0) begin
            check({tag, "_abort_reached"}, ab, 2);
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                check({tag, "_no_done"}, frame_done, 0);
                check({tag, "_no_valid"}, digit_valid, 0);
            end
        end else begin
            check({tag, "_first_valid_cycle"}, first_k, exp_first);
            check({tag, "_frame_done_cycle"}, fd_k, exp_fd);
            check({tag, "_frame_done_count"}, fd_cnt, 1);
            check({tag, "_err_end"}, err, exp_err);
            check({tag, "_queue_empty"}, exp_q.size(), 0);
        end
    endtask

    initial begin
        rst         = 1'b1;
        load        = 1'b1;
        base3_no    = 32'h0000_0006;
        digit_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_valid", digit_valid, 0);
        check("reset_last", digit_last, 0);
        check("reset_done", frame_done, 0);
        check("reset_err", err, 0);
        check("reset_digit", digit_out, 0);
        @(posedge clk); #1;
        rst  = 1'b0;
        load = 1'b0;
        @(negedge clk);
        check("load_during_rst_ignored", busy, 0);

        run_frame(32'h0000_0006, -1, -1, F6, 17, 1'b0, "f6");
        run_frame(32'h0000_0000, -1, -1, F0, 17, 1'b0, "zero");
        run_frame(32'h9A65_2418,  5, -1, 1,  20, 1'b0, "bp");
        run_frame(32'h0000_0003, -1, -1, F3, 17, 1'b1, "bad");
        run_frame(32'h0000_0006, -1, -1, F6, 17, 1'b0, "clr");
        run_frame(32'h9A65_2418, -1,  5, -1, -1, 1'b0, "abort");
        run_frame(32'h9A65_2418, -1, -1, 1,  17, 1'b0, "after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
